// File: rtl/mips_pkg.sv
// Shared MIPS-32 decode definitions: opcodes, format
// and ALU-op encodings, control bundle, immediate extender.
package mips_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  typedef enum logic [1:0] {
    FMT_R   = 2'b00,
    FMT_I   = 2'b01,
    FMT_J   = 2'b10,
    FMT_ILL = 2'b11
  } fmt_e;

  typedef enum logic [1:0] {
    ALU_ADD   = 2'b00,
    ALU_SUB   = 2'b01,
    ALU_FUNCT = 2'b10,
    ALU_OPC   = 2'b11
  } aluop_e;

  typedef struct packed {
    fmt_e   fmt;
    aluop_e alu_op;
    logic   reg_dst;
    logic   alu_src;
    logic   mem_to_reg;
    logic   reg_write;
    logic   mem_read;
    logic   mem_write;
    logic   branch;
    logic   branch_ne;
    logic   jump;
    logic   link;
    logic   illegal;
  } ctrl_t;

  // Logic immediates are unsigned; lui places imm in the upper half.
  function automatic logic [31:0] ext_imm(
    input logic [5:0]  op,
    input logic [15:0] imm
  );
    logic [31:0] r;
    if (op == OP_ANDI || op == OP_ORI)
      r = {16'h0, imm};
    else if (op == OP_LUI)
      r = {imm, 16'h0};
    else
      r = {{16{imm[15]}}, imm};
    return r;
  endfunction

endpackage

// File: rtl/decod_ctrl.sv
// Main control decode: opcode to strobes, format
// and illegal flag. Purely combinational.
module decod_ctrl
  import mips_pkg::*;
(
  input  logic [5:0] opcode,
  output ctrl_t      ctrl
);

  always_comb begin
    ctrl = '0;
    unique case (1'b1)
      (opcode == OP_RTYPE): begin
        ctrl.fmt       = FMT_R;
        ctrl.reg_dst   = 1'b1;
        ctrl.reg_write = 1'b1;
        ctrl.alu_op    = ALU_FUNCT;
      end
      (opcode == OP_LW): begin
        ctrl.fmt        = FMT_I;
        ctrl.alu_src    = 1'b1;
        ctrl.mem_to_reg = 1'b1;
        ctrl.reg_write  = 1'b1;
        ctrl.mem_read   = 1'b1;
        ctrl.alu_op     = ALU_ADD;
      end
      (opcode == OP_SW): begin
        ctrl.fmt       = FMT_I;
        ctrl.alu_src   = 1'b1;
        ctrl.mem_write = 1'b1;
        ctrl.alu_op    = ALU_ADD;
      end
      (opcode == OP_BEQ): begin
        ctrl.fmt    = FMT_I;
        ctrl.branch = 1'b1;
        ctrl.alu_op = ALU_SUB;
      end
      (opcode == OP_BNE): begin
        ctrl.fmt       = FMT_I;
        ctrl.branch    = 1'b1;
        ctrl.branch_ne = 1'b1;
        ctrl.alu_op    = ALU_SUB;
      end
      (opcode == OP_ADDI): begin
        ctrl.fmt       = FMT_I;
        ctrl.alu_src   = 1'b1;
        ctrl.reg_write = 1'b1;
        ctrl.alu_op    = ALU_ADD;
      end
      (opcode == OP_SLTI || opcode == OP_ANDI ||
       opcode == OP_ORI  || opcode == OP_LUI): begin
        ctrl.fmt       = FMT_I;
        ctrl.alu_src   = 1'b1;
        ctrl.reg_write = 1'b1;
        ctrl.alu_op    = ALU_OPC;
      end
      (opcode == OP_J): begin
        ctrl.fmt  = FMT_J;
        ctrl.jump = 1'b1;
      end
      (opcode == OP_JAL): begin
        ctrl.fmt       = FMT_J;
        ctrl.jump      = 1'b1;
        ctrl.link      = 1'b1;
        ctrl.reg_write = 1'b1;
      end
      default: begin
        ctrl.fmt     = FMT_ILL;
        ctrl.illegal = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/decodificador.sv
// Registered MIPS-32 decoder: field slicing, immediate
// extension and main control, one cycle of latency.
module decodificador
  import mips_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        instr_valid,
  input  logic [31:0] instrucao,
  output logic        valid,
  output logic [5:0]  opcode,
  output logic [4:0]  rs,
  output logic [4:0]  rt,
  output logic [4:0]  rd,
  output logic [4:0]  shamt,
  output logic [5:0]  funct,
  output logic [15:0] address,
  output logic [25:0] addressJ,
  output logic [31:0] imm_ext,
  output logic [1:0]  fmt,
  output logic        reg_dst,
  output logic        alu_src,
  output logic        mem_to_reg,
  output logic        reg_write,
  output logic        mem_read,
  output logic        mem_write,
  output logic        branch,
  output logic        branch_ne,
  output logic        jump,
  output logic        link,
  output logic [1:0]  alu_op,
  output logic        illegal
);

  ctrl_t c;
  logic  v;

  decod_ctrl u_ctrl (
    .opcode (instrucao[31:26]),
    .ctrl   (c)
  );

  assign v = instr_valid;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid      <= 1'b0;
      opcode     <= '0;
      rs         <= '0;
      rt         <= '0;
      rd         <= '0;
      shamt      <= '0;
      funct      <= '0;
      address    <= '0;
      addressJ   <= '0;
      imm_ext    <= '0;
      fmt        <= '0;
      reg_dst    <= 1'b0;
      alu_src    <= 1'b0;
      mem_to_reg <= 1'b0;
      reg_write  <= 1'b0;
      mem_read   <= 1'b0;
      mem_write  <= 1'b0;
      branch     <= 1'b0;
      branch_ne  <= 1'b0;
      jump       <= 1'b0;
      link       <= 1'b0;
      alu_op     <= '0;
      illegal    <= 1'b0;
    end else begin
      valid      <= v;
      opcode     <= instrucao[31:26];
      rs         <= instrucao[25:21];
      rt         <= instrucao[20:16];
      rd         <= instrucao[15:11];
      shamt      <= instrucao[10:6];
      funct      <= instrucao[5:0];
      address    <= instrucao[15:0];
      addressJ   <= instrucao[25:0];
      imm_ext    <= ext_imm(instrucao[31:26],
                            instrucao[15:0]);
      fmt        <= c.fmt;
      reg_dst    <= c.reg_dst;
      alu_src    <= c.alu_src;
      mem_to_reg <= c.mem_to_reg;
      alu_op     <= c.alu_op;
      // Side-effecting strobes are squashed on bubbles.
      reg_write  <= v & c.reg_write;
      mem_read   <= v & c.mem_read;
      mem_write  <= v & c.mem_write;
      branch     <= v & c.branch;
      branch_ne  <= v & c.branch_ne;
      jump       <= v & c.jump;
      link       <= v & c.link;
      illegal    <= v & c.illegal;
    end
  end

endmodule

// File: tb/tb_decodificador.sv
// Self-checking bench for decodificador: directed cases
// plus randomized stream against a behavioural model.
module tb_decodificador;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        instr_valid;
  logic [31:0] instrucao;
  logic        valid;
  logic [5:0]  opcode;
  logic [4:0]  rs, rt, rd, shamt;
  logic [5:0]  funct;
  logic [15:0] address;
  logic [25:0] addressJ;
  logic [31:0] imm_ext;
  logic [1:0]  fmt;
  logic        reg_dst, alu_src, mem_to_reg, reg_write;
  logic        mem_read, mem_write, branch, branch_ne;
  logic        jump, link, illegal;
  logic [1:0]  alu_op;

  int checks = 0;
  int errors = 0;

  decodificador dut (
    .clk(clk), .rst_n(rst_n),
    .instr_valid(instr_valid), .instrucao(instrucao),
    .valid(valid), .opcode(opcode), .rs(rs), .rt(rt),
    .rd(rd), .shamt(shamt), .funct(funct),
    .address(address), .addressJ(addressJ),
    .imm_ext(imm_ext), .fmt(fmt), .reg_dst(reg_dst),
    .alu_src(alu_src), .mem_to_reg(mem_to_reg),
    .reg_write(reg_write), .mem_read(mem_read),
    .mem_write(mem_write), .branch(branch),
    .branch_ne(branch_ne), .jump(jump), .link(link),
    .alu_op(alu_op), .illegal(illegal)
  );

  always #5 clk = ~clk;

  // Expected output vector, built from the ISA rules with
  // shifts/masks and a per-opcode table of named flags.
  function automatic logic [121:0] model(
    input logic [31:0] i, input logic v
  );
    logic [31:0] op, imm, ext;
    logic [1:0]  f, ao;
    logic rdst, asrc, m2r, rw, mr, mw, br, bn, jp, lk, il;
    op  = i >> 26;
    imm = i & 32'hFFFF;
    if (op == 32'h0C || op == 32'h0D) ext = imm;
    else if (op == 32'h0F) ext = imm * 65536;
    else if (imm >= 32'h8000) ext = imm + 32'hFFFF0000;
    else ext = imm;
    {rdst, asrc, m2r, rw, mr, mw, br, bn, jp, lk} = '0;
    il = 1'b0; ao = 2'd0; f = 2'd1;
    case (op)
      32'h00: begin f = 0; rdst = 1; rw = 1; ao = 2; end
      32'h23: begin asrc = 1; m2r = 1; rw = 1; mr = 1; end
      32'h2B: begin asrc = 1; mw = 1; end
      32'h04: begin br = 1; ao = 1; end
      32'h05: begin br = 1; bn = 1; ao = 1; end
      32'h08: begin asrc = 1; rw = 1; end
      32'h0A, 32'h0C, 32'h0D, 32'h0F:
        begin asrc = 1; rw = 1; ao = 3; end
      32'h02: begin f = 2; jp = 1; end
      32'h03: begin f = 2; jp = 1; lk = 1; rw = 1; end
      default: begin f = 3; il = 1; end
    endcase
    if (!v) {rw, mr, mw, br, bn, jp, lk, il} = '0;
    return {v, op[5:0],
            5'((i >> 21) & 31), 5'((i >> 16) & 31),
            5'((i >> 11) & 31), 5'((i >> 6) & 31),
            6'(i & 63), imm[15:0], 26'(i & 32'h3FFFFFF),
            ext, f, ao, rdst, asrc, m2r, rw, mr, mw,
            br, bn, jp, lk, il};
  endfunction

  function automatic logic [121:0] actual();
    return {valid, opcode, rs, rt, rd, shamt, funct,
            address, addressJ, imm_ext, fmt, alu_op,
            reg_dst, alu_src, mem_to_reg, reg_write,
            mem_read, mem_write, branch, branch_ne,
            jump, link, illegal};
  endfunction

  task automatic step(input logic [31:0] i, input logic v);
    @(negedge clk);
    instrucao   = i;
    instr_valid = v;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst_n = 1'b0;
    instrucao = 32'hFFFFFFFF;
    instr_valid = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if (actual() !== '0) begin
      errors++;
      $display("FAIL reset: got %h want 0", actual());
    end
    checks++;
    if (valid !== 1'b0 || fmt !== 2'b00) begin
      errors++;
      $display("FAIL reset_valid: got %b/%b want 0/00",
               valid, fmt);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_lw();
    step(32'h8D2804B0, 1'b1);
    checks++;
    if ({opcode, rs, rt, rd, shamt, funct} !==
        {6'h23, 5'd9, 5'd8, 5'd0, 5'd18, 6'h30}) begin
      errors++;
      $display("FAIL lw_fields: got %h %0d %0d %0d %0d %h",
               opcode, rs, rt, rd, shamt, funct);
    end
    checks++;
    if ({address, imm_ext, fmt, mem_read, mem_to_reg,
         alu_src, reg_write} !==
        {16'h04B0, 32'h000004B0, 2'b01, 4'b1111}) begin
      errors++;
      $display("FAIL lw_ctrl: got %h %h %b %b%b%b%b",
               address, imm_ext, fmt, mem_read,
               mem_to_reg, alu_src, reg_write);
    end
    checks++;
    if (actual() !== model(32'h8D2804B0, 1'b1)) begin
      errors++;
      $display("FAIL lw_all: got %h want %h", actual(),
               model(32'h8D2804B0, 1'b1));
    end
  endtask

  task automatic test_rtype_jump();
    step(32'h02484020, 1'b1);
    checks++;
    if ({opcode, rs, rt, rd, shamt, funct, fmt,
         reg_dst, reg_write, alu_op} !==
        {6'h0, 5'd18, 5'd8, 5'd8, 5'd0, 6'h20, 2'b00,
         2'b11, 2'b10}) begin
      errors++;
      $display("FAIL add: got %h want %h", actual(),
               model(32'h02484020, 1'b1));
    end
    step(32'h092804B0, 1'b1);
    checks++;
    if ({opcode, addressJ, fmt, jump, reg_write} !==
        {6'h02, 26'h12804B0, 2'b10, 2'b10}) begin
      errors++;
      $display("FAIL j: got %h %h %b %b %b", opcode,
               addressJ, fmt, jump, reg_write);
    end
  endtask

  task automatic test_imm_ext();
    logic [31:0] ins [3];
    logic [31:0] exp [3];
    ins = '{32'h2022FFFC, 32'h3422FFFC, 32'h3C021234};
    exp = '{32'hFFFFFFFC, 32'h0000FFFC, 32'h12340000};
    for (int k = 0; k < 3; k++) begin
      step(ins[k], 1'b1);
      checks++;
      if (imm_ext !== exp[k]) begin
        errors++;
        $display("FAIL imm_ext[%0d]: got %h want %h",
                 k, imm_ext, exp[k]);
      end
    end
  endtask

  task automatic test_illegal();
    step(32'hFC123456, 1'b1);
    checks++;
    if ({illegal, fmt, reg_write, mem_read, mem_write,
         branch, branch_ne, jump, link} !==
        {1'b1, 2'b11, 7'b0}) begin
      errors++;
      $display("FAIL illegal: got %h want %h", actual(),
               model(32'hFC123456, 1'b1));
    end
    checks++;
    if (addressJ !== 26'h0123456) begin
      errors++;
      $display("FAIL illegal_fields: got %h want 0123456",
               addressJ);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] seq [4];
    logic        vs  [4];
    seq = '{32'h8C430010, 32'hAC430010,
            32'h1043FFFE, 32'hAC430010};
    vs  = '{1'b1, 1'b1, 1'b1, 1'b0};
    for (int k = 0; k < 4; k++) begin
      step(seq[k], vs[k]);
      checks++;
      if (actual() !== model(seq[k], vs[k])) begin
        errors++;
        $display("FAIL b2b[%0d]: got %h want %h", k,
                 actual(), model(seq[k], vs[k]));
      end
    end
    checks++;
    if (mem_write !== 1'b0 || valid !== 1'b0) begin
      errors++;
      $display("FAIL bubble: got mw=%b v=%b want 0/0",
               mem_write, valid);
    end
  endtask

  task automatic test_reset_release();
    @(negedge clk);
    rst_n = 1'b0;
    instrucao = 32'h0C000005;
    instr_valid = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    instrucao = 32'h14A6FFF0;
    @(posedge clk);
    #1;
    checks++;
    if (actual() !== model(32'h14A6FFF0, 1'b1)) begin
      errors++;
      $display("FAIL reset_release: got %h want %h",
               actual(), model(32'h14A6FFF0, 1'b1));
    end
  endtask

  task automatic test_random();
    logic [5:0] ops [13];
    logic [31:0] i;
    logic        v;
    int          n;
    ops = '{6'h00, 6'h02, 6'h03, 6'h04, 6'h05, 6'h08,
            6'h0A, 6'h0C, 6'h0D, 6'h0F, 6'h23, 6'h2B,
            6'h3F};
    n = 0;
    for (int k = 0; k < 300; k++) begin
      i = $urandom;
      if ($urandom_range(0, 3) != 0)
        i[31:26] = ops[$urandom_range(0, 12)];
      v = ($urandom_range(0, 4) != 0);
      step(i, v);
      checks++;
      if (actual() !== model(i, v)) begin
        errors++;
        n++;
        if (n <= 10)
          $display("FAIL rand[%0d] %h v=%b: got %h want %h",
                   k, i, v, actual(), model(i, v));
      end
    end
  endtask

  initial begin
    rst_n = 1'b0;
    instr_valid = 1'b0;
    instrucao = '0;
    test_reset();
    test_lw();
    test_rtype_jump();
    test_imm_ext();
    test_illegal();
    test_back_to_back();
    test_reset_release();
    test_random();
    test_reset();
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule

// File: doc/decodificador.md
# decodificador

Registered MIPS-32 instruction decoder for the single-issue datapath. It sits between instruction fetch and the register file / control stage. It splits a 32-bit instruction word into the standard R/I/J fields, classifies the format, sign- or zero-extends the immediate, and produces main-control strobes. All outputs are registered, with one cycle of latency.

## Interface
No parameters; widths are fixed by the MIPS-32 ISA.
- clk  in  1  single clock; all state updates on rising edge
- rst_n  in  1  synchronous, active-low reset
- instr_valid  in  1  instrucao is valid this cycle
- instrucao  in  32  instruction word
- valid  out  1  registered copy of instr_valid
- opcode  out  6  instrucao[31:26]
- rs  out  5  instrucao[25:21]
- rt  out  5  instrucao[20:16]
- rd  out  5  instrucao[15:11]
- shamt  out  5  instrucao[10:6]
- funct  out  6  instrucao[5:0]
- address  out  16  instrucao[15:0], raw immediate/offset
- addressJ  out  26  instrucao[25:0], raw jump target
- imm_ext  out  32  extended immediate (see Operation)
- fmt  out  2  format: 00 R, 01 I, 10 J, 11 illegal
- reg_dst, alu_src, mem_to_reg, reg_write, mem_read, mem_write, branch, branch_ne, jump, link  out  1 each  main-control strobes
- alu_op  out  2  00 add, 01 sub, 10 use funct, 11 use opcode (immediate logic/compare)
- illegal  out  1  opcode not in supported set

## Operation
- Field outputs are pure bit slices, independent of opcode. They are always produced, even for illegal opcodes.
- imm_ext is zero-extended for andi (0x0C) and ori (0x0D).
- imm_ext is {address, 16'h0} for lui (0x0F).
- imm_ext is sign-extended for all other opcodes.
- Control by opcode (unlisted strobes are 0):
  - 0x00 R-type: fmt=00, reg_dst, reg_write, alu_op=10.
  - 0x23 lw: fmt=01, alu_src, mem_to_reg, reg_write, mem_read, alu_op=00.
  - 0x2B sw: fmt=01, alu_src, mem_write, alu_op=00.
  - 0x04 beq: fmt=01, branch, alu_op=01.
  - 0x05 bne: fmt=01, branch, branch_ne, alu_op=01.
  - 0x08 addi: fmt=01, alu_src, reg_write, alu_op=00.
  - 0x0A slti / 0x0C andi / 0x0D ori / 0x0F lui: fmt=01, alu_src, reg_write, alu_op=11.
  - 0x02 j: fmt=10, jump.
  - 0x03 jal: fmt=10, jump, link, reg_write.
- Any other opcode: fmt=11, illegal=1, all strobes 0, alu_op=00. Field outputs are still sliced.
- When instr_valid=0, the registered strobes (reg_write, mem_read, mem_write, branch, branch_ne, jump, link) are forced to 0 and illegal=0. Fields, imm_ext and fmt still update, so the no-op bubble is safe.

## Timing
- Single register stage: inputs sampled at edge N appear on outputs after edge N; latency is 1 cycle, with throughput of one instruction per cycle.
- No handshake or stall; a new instruction is accepted every cycle.
- Reset: when rst_n=0 at an edge, every output goes to 0 (fmt=00, valid=0, illegal=0). This overrides any input in the same cycle.
- Reset released mid-stream: the first post-reset output reflects the instruction sampled at the first edge with rst_n=1.
- The decoder holds no other state and has no wrap-around or overflow cases.

## Structure
- Shared package (mips_pkg): opcode constants (OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_BNE, OP_ADDI, OP_SLTI, OP_ANDI, OP_ORI, OP_LUI, OP_J, OP_JAL), fmt encodings, and alu_op encodings.
- One combinational sub-module, decod_ctrl: opcode in, control strobes, fmt and illegal out. The top level slices fields, extends the immediate, applies instr_valid gating and registers everything.

## Test plan
- Reset: rst_n=0 with instrucao=0xFFFFFFFF, instr_valid=1 -> after the edge, all outputs are 0 and valid=0.
- lw 0x8D2804B0, valid=1 -> next cycle: opcode=0x23, rs=9, rt=8, rd=0, shamt=18, funct=0x30, address=0x04B0, imm_ext=0x000004B0, fmt=01, mem_read=mem_to_reg=alu_src=reg_write=1.
- add 0x02484020 -> opcode=0, rs=18, rt=8, rd=8, shamt=0, funct=0x20, fmt=00, reg_dst=reg_write=1, alu_op=10.
- j 0x092804B0 -> opcode=0x02, addressJ=0x12804B0, fmt=10, jump=1, reg_write=0.
- Immediate extension:
  - addi with imm 0xFFFC -> imm_ext=0xFFFFFFFC.
  - ori with imm 0xFFFC -> imm_ext=0x0000FFFC.
  - lui with imm 0x1234 -> imm_ext=0x12340000.
- Illegal opcode 0x3F -> illegal=1, fmt=11, all strobes 0.
- Back-to-back lw/sw/beq, then the same sw with instr_valid=0 -> each result one cycle later; for the invalid cycle, mem_write=0 and valid=0.
